// File: rtl/mem_output_collector.sv
// Reassembles a descending-index word stream into one block.
// One collection buffer plus one output buffer for the consumer.
module mem_output_collector #(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 16,
    parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    input  logic [WORD_W-1:0]                in_word,
    output logic                             in_ready,
    output logic                             block_valid,
    output logic [NUM_WORDS-1:0][WORD_W-1:0] out_block,
    input  logic                             block_ack,
    output logic [CNT_W-1:0]                 word_count
);

    typedef enum logic {
        S_COLLECT,
        S_WAIT
    } state_t;

    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] block_t;

    state_t state;
    block_t coll;
    block_t next_block;

    logic accept;
    logic last;
    logic ack_eff;

    assign in_ready = rst && (state == S_COLLECT);
    assign accept   = in_valid && in_ready && !flush;
    assign last     = (word_count == CNT_W'(NUM_WORDS - 1));
    assign ack_eff  = block_ack && block_valid;

    // Full block as it looks once the word arriving now lands in slot 0.
    always_comb begin
        next_block    = coll;
        next_block[0] = in_word;
    end

    // Collection, hand-off to the output buffer, and the COLLECT/WAIT FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_COLLECT;
            word_count  <= '0;
            block_valid <= 1'b0;
            out_block   <= '0;
            coll        <= '0;
        end else begin
            // The first word of a block goes to the highest index.
            if (accept) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (word_count == CNT_W'(NUM_WORDS - 1 - i)) begin
                        coll[i] <= in_word;
                    end
                end
            end

            if (flush) begin
                // Partial or pending block is dropped; an ack is still honoured.
                word_count <= '0;
                state      <= S_COLLECT;
                if (ack_eff) begin
                    block_valid <= 1'b0;
                end
            end else if (state == S_WAIT) begin
                if (ack_eff) begin
                    out_block   <= coll;
                    block_valid <= 1'b1;
                    word_count  <= '0;
                    state       <= S_COLLECT;
                end
            end else if (accept && last) begin
                if (!block_valid || block_ack) begin
                    out_block   <= next_block;
                    block_valid <= 1'b1;
                    word_count  <= '0;
                end else begin
                    state <= S_WAIT;
                end
            end else begin
                if (accept) begin
                    word_count <= word_count + CNT_W'(1);
                end
                if (ack_eff) begin
                    block_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_output_collector.sv
// Directed bench for mem_output_collector.
// Expected blocks are built from the stream base value.
module tb_mem_output_collector;

    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 16;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);

    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] blk_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              in_ready;
    logic              block_valid;
    blk_t              out_block;
    logic              block_ack;
    logic [CNT_W-1:0]  word_count;

    int checks;
    int errors;

    mem_output_collector #(
        .WORD_W(WORD_W),
        .NUM_WORDS(NUM_WORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_word(in_word),
        .in_ready(in_ready),
        .block_valid(block_valid),
        .out_block(out_block),
        .block_ack(block_ack),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word k of a stream starting at base lands at index NUM_WORDS-1-k.
    function automatic blk_t build(input logic [WORD_W-1:0] base);
        blk_t b;
        for (int k = 0; k < NUM_WORDS; k++) begin
            b[NUM_WORDS-1-k] = base + WORD_W'(k);
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WORD_W-1:0] w);
        in_valid = 1'b1;
        in_word  = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 0", in_ready);
        end
        checks++;
        if (block_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_block_valid got %b exp 0", block_valid);
        end
        checks++;
        if (word_count !== '0) begin
            errors++;
            $display("FAIL reset_word_count got %0d exp 0", word_count);
        end
        checks++;
        if (out_block !== '0) begin
            errors++;
            $display("FAIL reset_out_block got %h exp 0", out_block);
        end
        rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_single_block();
        for (int k = 0; k < NUM_WORDS - 1; k++) begin
            push(16'h0F00 + 16'(k));
        end
        checks++;
        if (word_count !== CNT_W'(15) || block_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_partial got cnt=%0d bv=%b exp cnt=15 bv=0",
                     word_count, block_valid);
        end
        push(16'h0F0F);
        checks++;
        if (block_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid got %b exp 1", block_valid);
        end
        checks++;
        if (out_block !== build(16'h0F00)) begin
            errors++;
            $display("FAIL single_block got %h exp %h", out_block, build(16'h0F00));
        end
        checks++;
        if (out_block[15] !== 16'h0F00 || out_block[0] !== 16'h0F0F) begin
            errors++;
            $display("FAIL single_ends got [15]=%h [0]=%h exp 0f00 0f0f",
                     out_block[15], out_block[0]);
        end
        checks++;
        if (word_count !== '0) begin
            errors++;
            $display("FAIL single_count got %0d exp 0", word_count);
        end
    endtask

    task automatic test_wait();
        block_ack = 1'b0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            push(16'hA000 + 16'(k));
        end
        checks++;
        if (in_ready !== 1'b0 || word_count !== CNT_W'(15)) begin
            errors++;
            $display("FAIL wait_enter got rdy=%b cnt=%0d exp rdy=0 cnt=15",
                     in_ready, word_count);
        end
        push(16'hDEAD);
        checks++;
        if (out_block !== build(16'h0F00) || block_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_hold got bv=%b %h exp bv=1 %h",
                     block_valid, out_block, build(16'h0F00));
        end
        block_ack = 1'b1;
        step();
        block_ack = 1'b0;
        checks++;
        if (out_block !== build(16'hA000) || block_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_xfer got bv=%b %h exp bv=1 %h",
                     block_valid, out_block, build(16'hA000));
        end
        checks++;
        if (word_count !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_exit got cnt=%0d rdy=%b exp cnt=0 rdy=1",
                     word_count, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic dropped;
        dropped = 1'b0;
        for (int k = 0; k < NUM_WORDS - 1; k++) begin
            push(16'hC000 + 16'(k));
            if (block_valid !== 1'b1) dropped = 1'b1;
        end
        block_ack = 1'b1;
        push(16'hC00F);
        block_ack = 1'b0;
        if (block_valid !== 1'b1) dropped = 1'b1;
        checks++;
        if (dropped !== 1'b0) begin
            errors++;
            $display("FAIL b2b_valid_drop got 1 exp 0");
        end
        checks++;
        if (out_block !== build(16'hC000) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_block got rdy=%b %h exp rdy=1 %h",
                     in_ready, out_block, build(16'hC000));
        end
        block_ack = 1'b1;
        step();
        block_ack = 1'b0;
        checks++;
        if (block_valid !== 1'b0 || out_block !== build(16'hC000)) begin
            errors++;
            $display("FAIL ack_clear got bv=%b %h exp bv=0 %h",
                     block_valid, out_block, build(16'hC000));
        end
        block_ack = 1'b1;
        step();
        block_ack = 1'b0;
        checks++;
        if (block_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle got bv=%b exp 0", block_valid);
        end
    endtask

    task automatic test_gapped();
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (word_count !== CNT_W'(k)) bad = 1'b1;
            push(16'h0F00 + 16'(k));
            step();
            step();
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL gap_count_steps got bad exp monotonic 0..15");
        end
        checks++;
        if (block_valid !== 1'b1 || out_block !== build(16'h0F00)) begin
            errors++;
            $display("FAIL gap_block got bv=%b %h exp bv=1 %h",
                     block_valid, out_block, build(16'h0F00));
        end
        block_ack = 1'b1;
        step();
        block_ack = 1'b0;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) begin
            push(16'hE000 + 16'(k));
        end
        flush = 1'b1;
        push(16'hEEEE);
        flush = 1'b0;
        checks++;
        if (word_count !== '0 || block_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_count got cnt=%0d bv=%b exp cnt=0 bv=0",
                     word_count, block_valid);
        end
        for (int k = 0; k < NUM_WORDS; k++) begin
            push(16'hB000 + 16'(k));
        end
        checks++;
        if (block_valid !== 1'b1 || out_block !== build(16'hB000)) begin
            errors++;
            $display("FAIL flush_block got bv=%b %h exp bv=1 %h",
                     block_valid, out_block, build(16'hB000));
        end
        for (int k = 0; k < NUM_WORDS; k++) begin
            push(16'h9000 + 16'(k));
        end
        flush = 1'b1;
        block_ack = 1'b1;
        step();
        flush = 1'b0;
        block_ack = 1'b0;
        checks++;
        if (block_valid !== 1'b0 || out_block !== build(16'hB000)) begin
            errors++;
            $display("FAIL flush_wait got bv=%b %h exp bv=0 %h",
                     block_valid, out_block, build(16'hB000));
        end
        checks++;
        if (word_count !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait_state got cnt=%0d rdy=%b exp 0 1",
                     word_count, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 7; k++) begin
            push(16'h5000 + 16'(k));
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b0 || word_count !== '0 || block_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_partial got rdy=%b cnt=%0d bv=%b exp 0 0 0",
                     in_ready, word_count, block_valid);
        end
        rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_release got %b exp 1", in_ready);
        end
        for (int k = 0; k < NUM_WORDS; k++) begin
            push(16'hD000 + 16'(k));
        end
        for (int k = 0; k < NUM_WORDS; k++) begin
            push(16'h8000 + 16'(k));
        end
        checks++;
        if (in_ready !== 1'b0 || out_block !== build(16'hD000)) begin
            errors++;
            $display("FAIL rstmid_wait got rdy=%b %h exp rdy=0 %h",
                     in_ready, out_block, build(16'hD000));
        end
        rst = 1'b0;
        step();
        checks++;
        if (block_valid !== 1'b0 || word_count !== '0 ||
            out_block !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_wait_clear got bv=%b cnt=%0d rdy=%b %h exp 0",
                     block_valid, word_count, in_ready, out_block);
        end
        rst = 1'b1;
        step();
        for (int k = 0; k < NUM_WORDS; k++) begin
            push(16'h7000 + 16'(k));
        end
        checks++;
        if (block_valid !== 1'b1 || out_block !== build(16'h7000)) begin
            errors++;
            $display("FAIL rstmid_after got bv=%b %h exp bv=1 %h",
                     block_valid, out_block, build(16'h7000));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        block_ack = 1'b0;
        test_reset();
        test_single_block();
        test_wait();
        test_back_to_back();
        test_gapped();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
